// File: rtl/ysyx_24080006_sysu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080006_pkg
// Brief    : Shared types for the system-instruction unit and the CSR file.
// Revision : 1.0
// ============================================================================
package ysyx_24080006_pkg;

   typedef enum logic [2:0] {
      SYS_CSRRW  = 3'd0,
      SYS_CSRRS  = 3'd1,
      SYS_CSRRC  = 3'd2,
      SYS_ECALL  = 3'd3,
      SYS_MRET   = 3'd4,
      SYS_FENCEI = 3'd5
   } sys_op_e;

   typedef enum logic [1:0] {
      SYSU_IDLE  = 2'd0,
      SYSU_EXEC  = 2'd1,
      SYSU_FLUSH = 2'd2,
      SYSU_RESP  = 2'd3
   } sysu_state_e;

   typedef enum logic [1:0] {
      CSR_READ  = 2'd0,
      CSR_WRITE = 2'd1,
      CSR_SET   = 2'd2,
      CSR_CLEAR = 2'd3
   } csr_op_e;

   typedef struct packed {
      logic    csr_enable;
      csr_op_e csr_op;
   } csr_set_t;

   typedef enum logic [11:0] {
      MSTATUS = 12'h300,
      MTVEC   = 12'h305,
      MEPC    = 12'h341,
      MCAUSE  = 12'h342
   } system_e;

   // Immediate forms carry a zero-extended 5-bit zimm in place of rs1.
   function automatic logic [31:0] sysu_operand(input logic use_imm,
                                                input logic [4:0] zimm,
                                                input logic [31:0] rs1);
      return use_imm ? {27'd0, zimm} : rs1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24080006_sysu_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080006_sysu_if
// Brief    : Issue/result handshake between the execute stage and the SYSU.
// Revision : 1.0
// ============================================================================
interface ysyx_24080006_sysu_if
   import ysyx_24080006_pkg::*;
;
   logic        in_valid;
   logic        in_ready;
   sys_op_e     in_op;
   logic        in_use_imm;
   logic [4:0]  in_zimm;
   logic [31:0] in_rs1_data;
   logic        in_rs1_zero;
   system_e     in_csr_name;
   logic [31:0] in_pc;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rd_data;
   logic        out_redirect;
   logic [31:0] out_redirect_pc;

   modport master (
      output in_valid, in_op, in_use_imm, in_zimm, in_rs1_data, in_rs1_zero,
             in_csr_name, in_pc, out_ready,
      input  in_ready, out_valid, out_rd_data, out_redirect, out_redirect_pc
   );

   modport slave (
      input  in_valid, in_op, in_use_imm, in_zimm, in_rs1_data, in_rs1_zero,
             in_csr_name, in_pc, out_ready,
      output in_ready, out_valid, out_rd_data, out_redirect, out_redirect_pc
   );

endinterface
`default_nettype wire

// File: rtl/ysyx_24080006_sysu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080006_sysu
// Brief    : Serialising system-instruction unit driving the CSR file port.
//            Optional macro SYSU_FENCEI_EN adds the icache flush handshake.
// Revision : 1.0
// ============================================================================
module ysyx_24080006_sysu
   import ysyx_24080006_pkg::*;
(
   input  logic                       clock,
   input  logic                       reset,
   ysyx_24080006_sysu_if.slave        sif,
   output csr_set_t                   csr_set,
   output system_e                    csr_name,
   output logic [31:0]                csr_pc,
   output logic [31:0]                csr_wdata,
   input  logic [31:0]                csr_rdata,
   output logic                       ecall,
   output logic                       mret,
   output logic                       flush_req,
   input  logic                       flush_ack
);

   localparam logic [1:0] ST_IDLE  = SYSU_IDLE;
   localparam logic [1:0] ST_EXEC  = SYSU_EXEC;
   localparam logic [1:0] ST_RESP  = SYSU_RESP;
`ifdef SYSU_FENCEI_EN
   localparam logic [1:0] ST_FLUSH = SYSU_FLUSH;
`endif

   logic [1:0]  r_state;
   sys_op_e     r_op;
   logic [31:0] r_operand;
   system_e     r_name;
   logic [31:0] r_pc;
   logic        r_rs1_zero;
   logic [31:0] r_rd_data;
   logic        r_redirect;
   logic [31:0] r_redirect_pc;
   logic        w_exec;

   // Strobes are gated by reset so an aborted EXEC cycle commits nothing.
   assign w_exec = (r_state == ST_EXEC) && !reset;

   assign sif.in_ready        = (r_state == ST_IDLE);
   assign sif.out_valid       = (r_state == ST_RESP);
   assign sif.out_rd_data     = r_rd_data;
   assign sif.out_redirect    = r_redirect;
   assign sif.out_redirect_pc = r_redirect_pc;

`ifdef SYSU_FENCEI_EN
   assign flush_req = (r_state == ST_FLUSH);
`else
   logic w_unused_flush_ack;
   assign w_unused_flush_ack = flush_ack;
   assign flush_req          = 1'b0;
`endif

   always_comb begin
      csr_set.csr_enable = 1'b0;
      csr_set.csr_op     = CSR_READ;
      csr_name           = MSTATUS;
      csr_wdata          = 32'd0;
      csr_pc             = 32'd0;
      ecall              = 1'b0;
      mret               = 1'b0;
      if (w_exec) begin
         case (r_op)
            SYS_CSRRW: begin
               csr_set.csr_enable = 1'b1;
               csr_set.csr_op     = CSR_WRITE;
               csr_name           = r_name;
               csr_wdata          = r_operand;
            end
            SYS_CSRRS: begin
               csr_set.csr_enable = 1'b1;
               csr_set.csr_op     = r_rs1_zero ? CSR_READ : CSR_SET;
               csr_name           = r_name;
               csr_wdata          = r_operand;
            end
            SYS_CSRRC: begin
               csr_set.csr_enable = 1'b1;
               csr_set.csr_op     = r_rs1_zero ? CSR_READ : CSR_CLEAR;
               csr_name           = r_name;
               csr_wdata          = r_operand;
            end
            SYS_ECALL: begin
               csr_name = MTVEC;
               csr_pc   = r_pc;
               ecall    = 1'b1;
            end
            SYS_MRET: begin
               csr_name = MEPC;
               mret     = 1'b1;
            end
            SYS_FENCEI: begin
               csr_name = MSTATUS;
            end
            default: begin
               // Undefined encodings degrade to a plain CSR read.
               csr_set.csr_enable = 1'b1;
               csr_set.csr_op     = CSR_READ;
               csr_name           = r_name;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_op          <= SYS_CSRRW;
         r_operand     <= 32'd0;
         r_name        <= MSTATUS;
         r_pc          <= 32'd0;
         r_rs1_zero    <= 1'b0;
         r_rd_data     <= 32'd0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (sif.in_valid) begin
                  r_op       <= sif.in_op;
                  r_operand  <= sysu_operand(sif.in_use_imm, sif.in_zimm, sif.in_rs1_data);
                  r_name     <= sif.in_csr_name;
                  r_pc       <= sif.in_pc;
                  r_rs1_zero <= sif.in_rs1_zero;
                  r_state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_state <= ST_RESP;
               case (r_op)
                  SYS_ECALL, SYS_MRET: begin
                     r_rd_data     <= 32'd0;
                     r_redirect    <= 1'b1;
                     r_redirect_pc <= csr_rdata;
                  end
                  SYS_FENCEI: begin
                     r_rd_data     <= 32'd0;
                     r_redirect    <= 1'b1;
                     r_redirect_pc <= r_pc + 32'd4;
`ifdef SYSU_FENCEI_EN
                     r_state       <= ST_FLUSH;
`endif
                  end
                  default: begin
                     r_rd_data     <= csr_rdata;
                     r_redirect    <= 1'b0;
                     r_redirect_pc <= 32'd0;
                  end
               endcase
            end
`ifdef SYSU_FENCEI_EN
            ST_FLUSH: begin
               if (flush_ack) begin
                  r_state <= ST_RESP;
               end
            end
`endif
            ST_RESP: begin
               if (sif.out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080006_sysu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24080006_sysu
// Brief    : Scoreboard bench for the SYSU with a small behavioural CSR file.
// Revision : 1.0
// ============================================================================
module tb_ysyx_24080006_sysu;
   import ysyx_24080006_pkg::*;

   logic        clock;
   logic        reset;
   csr_set_t    csr_set;
   system_e     csr_name;
   logic [31:0] csr_pc;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        ecall;
   logic        mret;
   logic        flush_req;
   logic        flush_ack;

   ysyx_24080006_sysu_if sif ();

   ysyx_24080006_sysu dut (
      .clock     (clock),
      .reset     (reset),
      .sif       (sif),
      .csr_set   (csr_set),
      .csr_name  (csr_name),
      .csr_pc    (csr_pc),
      .csr_wdata (csr_wdata),
      .csr_rdata (csr_rdata),
      .ecall     (ecall),
      .mret      (mret),
      .flush_req (flush_req),
      .flush_ack (flush_ack)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural CSR file: mtvec keeps its low two mode bits cleared.
   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

   always_comb begin
      csr_rdata = 32'd0;
      case (csr_name)
         MSTATUS: csr_rdata = m_mstatus;
         MTVEC:   csr_rdata = m_mtvec;
         MEPC:    csr_rdata = m_mepc;
         MCAUSE:  csr_rdata = m_mcause;
         default: csr_rdata = 32'd0;
      endcase
   end

   always @(posedge clock) begin
      if (reset) begin
         m_mstatus <= 32'h0000_1800;
         m_mtvec   <= 32'd0;
         m_mepc    <= 32'd0;
         m_mcause  <= 32'd0;
      end else begin
         if (csr_set.csr_enable && csr_set.csr_op != CSR_READ) begin
            logic [31:0] v;
            case (csr_set.csr_op)
               CSR_WRITE: v = csr_wdata;
               CSR_SET:   v = csr_rdata | csr_wdata;
               default:   v = csr_rdata & ~csr_wdata;
            endcase
            case (csr_name)
               MSTATUS: m_mstatus <= v;
               MTVEC:   m_mtvec   <= v & ~32'h3;
               MEPC:    m_mepc    <= v;
               MCAUSE:  m_mcause  <= v;
               default: ;
            endcase
         end
         if (ecall) begin
            m_mepc   <= csr_pc;
            m_mcause <= 32'd11;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic void chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endfunction

   typedef struct {
      logic [31:0] rd;
      logic        redir;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];

   // Monitor: every accepted result is matched against the oldest expectation.
   always @(negedge clock) begin
      if (!reset && sif.out_valid && sif.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got rd %h with empty scoreboard", sif.out_rd_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_data", sif.out_rd_data, e.rd);
            chk1("redirect", sif.out_redirect, e.redir);
            if (e.redir) chk("redirect_pc", sif.out_redirect_pc, e.pc);
         end
      end
   end

   task automatic issue(input sys_op_e op, input logic use_imm, input logic [4:0] zimm,
                        input logic [31:0] rs1, input logic rs1_zero, input system_e name,
                        input logic [31:0] pc, input logic [31:0] exp_rd,
                        input logic exp_redir, input logic [31:0] exp_pc);
      int n = 0;
      while (!sif.in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk1("in_ready_before_issue", sif.in_ready, 1'b1);
      sif.in_valid    = 1'b1;
      sif.in_op       = op;
      sif.in_use_imm  = use_imm;
      sif.in_zimm     = zimm;
      sif.in_rs1_data = rs1;
      sif.in_rs1_zero = rs1_zero;
      sif.in_csr_name = name;
      sif.in_pc       = pc;
      sb.push_back('{exp_rd, exp_redir, exp_pc});
      @(posedge clock);
      #1;
      sif.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!sif.in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk1("idle_timeout", sif.in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      flush_ack       = 1'b0;
      sif.in_valid    = 1'b0;
      sif.in_op       = SYS_CSRRW;
      sif.in_use_imm  = 1'b0;
      sif.in_zimm     = 5'd0;
      sif.in_rs1_data = 32'd0;
      sif.in_rs1_zero = 1'b0;
      sif.in_csr_name = MSTATUS;
      sif.in_pc       = 32'd0;
      sif.out_ready   = 1'b1;

      repeat (2) @(posedge clock);
      @(negedge clock);
      chk1("rst_in_ready", sif.in_ready, 1'b1);
      chk1("rst_out_valid", sif.out_valid, 1'b0);
      chk1("rst_redirect", sif.out_redirect, 1'b0);
      chk("rst_rd_data", sif.out_rd_data, 32'd0);
      chk("rst_redirect_pc", sif.out_redirect_pc, 32'd0);
      chk1("rst_flush_req", flush_req, 1'b0);
      chk1("rst_ecall", ecall, 1'b0);
      chk1("rst_mret", mret, 1'b0);
      chk1("rst_csr_enable", csr_set.csr_enable, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // CSRRW mtvec <- 0x80000101
      issue(SYS_CSRRW, 1'b0, 5'd0, 32'h8000_0101, 1'b0, MTVEC, 32'h8000_0000, 32'd0, 1'b0, 32'd0);
      @(negedge clock);
      chk1("rw_enable", csr_set.csr_enable, 1'b1);
      chk("rw_op", 32'(csr_set.csr_op), 32'(CSR_WRITE));
      chk("rw_wdata", csr_wdata, 32'h8000_0101);
      chk("rw_name", 32'(csr_name), 32'(MTVEC));
      chk1("rw_in_ready_exec", sif.in_ready, 1'b0);
      chk1("rw_out_valid_exec", sif.out_valid, 1'b0);
      @(negedge clock);
      chk1("rw_out_valid_n2", sif.out_valid, 1'b1);
      wait_idle();

      // CSRRS x0 mtvec: read back masked value
      issue(SYS_CSRRS, 1'b0, 5'd0, 32'd0, 1'b1, MTVEC, 32'h8000_0004, 32'h8000_0100, 1'b0, 32'd0);
      @(negedge clock);
      chk("rs_x0_op", 32'(csr_set.csr_op), 32'(CSR_READ));
      wait_idle();

      // CSRRS mstatus x0
      issue(SYS_CSRRS, 1'b0, 5'd0, 32'hDEAD_BEEF, 1'b1, MSTATUS, 32'h8000_0008, 32'h0000_1800, 1'b0, 32'd0);
      @(negedge clock);
      chk("rs_mstatus_op", 32'(csr_set.csr_op), 32'(CSR_READ));
      chk1("rs_mstatus_en", csr_set.csr_enable, 1'b1);
      wait_idle();
      chk("mstatus_unchanged", m_mstatus, 32'h0000_1800);

      // CSRRSI mstatus, zimm=5 (rs1 data must be ignored)
      issue(SYS_CSRRS, 1'b1, 5'd5, 32'hFFFF_FFFF, 1'b0, MSTATUS, 32'h8000_000C, 32'h0000_1800, 1'b0, 32'd0);
      @(negedge clock);
      chk("rsi_op", 32'(csr_set.csr_op), 32'(CSR_SET));
      chk("rsi_wdata", csr_wdata, 32'd5);
      wait_idle();

      // CSRRCI mstatus, zimm=5
      issue(SYS_CSRRC, 1'b1, 5'd5, 32'd0, 1'b0, MSTATUS, 32'h8000_000C, 32'h0000_1805, 1'b0, 32'd0);
      @(negedge clock);
      chk("rci_op", 32'(csr_set.csr_op), 32'(CSR_CLEAR));
      wait_idle();
      chk("mstatus_after_clear", m_mstatus, 32'h0000_1800);

      // ECALL at 0x80000010
      issue(SYS_ECALL, 1'b0, 5'd0, 32'd0, 1'b0, MSTATUS, 32'h8000_0010, 32'd0, 1'b1, 32'h8000_0100);
      @(negedge clock);
      chk1("ecall_strobe", ecall, 1'b1);
      chk1("ecall_enable", csr_set.csr_enable, 1'b0);
      chk("ecall_pc", csr_pc, 32'h8000_0010);
      chk("ecall_name", 32'(csr_name), 32'(MTVEC));
      @(negedge clock);
      chk1("ecall_single", ecall, 1'b0);
      wait_idle();
      chk("mepc_after_ecall", m_mepc, 32'h8000_0010);
      chk("mcause_after_ecall", m_mcause, 32'd11);

      // MRET
      issue(SYS_MRET, 1'b0, 5'd0, 32'd0, 1'b0, MSTATUS, 32'h8000_0100, 32'd0, 1'b1, 32'h8000_0010);
      @(negedge clock);
      chk1("mret_strobe", mret, 1'b1);
      chk("mret_name", 32'(csr_name), 32'(MEPC));
      @(negedge clock);
      chk1("mret_single", mret, 1'b0);
      wait_idle();

      // Undefined op: plain read, no redirect
      issue(sys_op_e'(3'd7), 1'b0, 5'd0, 32'h1234, 1'b0, MSTATUS, 32'h8000_0020, 32'h0000_1800, 1'b0, 32'd0);
      @(negedge clock);
      chk("unk_op", 32'(csr_set.csr_op), 32'(CSR_READ));
      chk1("unk_enable", csr_set.csr_enable, 1'b1);
      chk1("unk_ecall", ecall, 1'b0);
      wait_idle();

      // FENCE.I at 0xFFFFFFFC, result back-pressured
      sif.out_ready = 1'b0;
      issue(SYS_FENCEI, 1'b0, 5'd0, 32'd0, 1'b0, MSTATUS, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'd0);
      @(negedge clock);
`ifdef SYSU_FENCEI_EN
      repeat (5) begin
         @(negedge clock);
         chk1("fence_flush_req", flush_req, 1'b1);
         chk1("fence_in_ready_flush", sif.in_ready, 1'b0);
         chk1("fence_no_valid_flush", sif.out_valid, 1'b0);
      end
      flush_ack = 1'b1;
      @(posedge clock);
      #1;
      flush_ack = 1'b0;
`else
      chk1("fence_flush_req_off", flush_req, 1'b0);
`endif
      repeat (3) begin
         @(negedge clock);
         chk1("fence_valid_held", sif.out_valid, 1'b1);
         chk1("fence_in_ready_resp", sif.in_ready, 1'b0);
         chk1("fence_redirect_held", sif.out_redirect, 1'b1);
         chk("fence_pc_held", sif.out_redirect_pc, 32'd0);
         chk1("fence_flush_req_resp", flush_req, 1'b0);
      end
      @(posedge clock);
      #1;
      sif.out_ready = 1'b1;
      wait_idle();

      // Reset while a result waits in RESP
      sif.out_ready = 1'b0;
      issue(SYS_CSRRS, 1'b0, 5'd0, 32'd0, 1'b1, MSTATUS, 32'h8000_0030, 32'h0000_1800, 1'b0, 32'd0);
      @(negedge clock);
      @(negedge clock);
      chk1("pre_reset_valid", sif.out_valid, 1'b1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      sif.out_ready = 1'b1;
      if (sb.size() != 0) sb.delete(0);
      @(negedge clock);
      chk1("rst_resp_valid", sif.out_valid, 1'b0);
      chk1("rst_resp_in_ready", sif.in_ready, 1'b1);

`ifdef SYSU_FENCEI_EN
      // Reset while waiting on the flush handshake
      issue(SYS_FENCEI, 1'b0, 5'd0, 32'd0, 1'b0, MSTATUS, 32'h8000_0040, 32'd0, 1'b1, 32'h8000_0044);
      @(negedge clock);
      @(negedge clock);
      chk1("pre_reset_flush", flush_req, 1'b1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      if (sb.size() != 0) sb.delete(0);
      @(negedge clock);
      chk1("rst_flush_req", flush_req, 1'b0);
      chk1("rst_flush_valid", sif.out_valid, 1'b0);
      chk1("rst_flush_in_ready", sif.in_ready, 1'b1);
`endif

      repeat (2) @(negedge clock);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
